// File: rtl/tx_scrambler_pkg.sv
// Shared constants for the per-lane TX scrambler: LFSR polynomials and seeds,
// LFSRSel encodings and the ordered-set symbols used by Master_Tx.
package tx_scrambler_pkg;

  // Galois feedback masks (polynomial without the x^W term)
  localparam logic [15:0] LFSR16_TAPS       = 16'h0039;  // x^16+x^5+x^4+x^3+1
  localparam logic [22:0] LFSR23_TAPS       = 23'h210125; // x^23+x^21+x^16+x^8+x^5+x^2+1
  localparam logic [15:0] LFSR16_SEED       = 16'hFFFF;
  localparam logic [22:0] LFSR23_SEED_LANE0 = 23'h1DBFBC;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  typedef enum logic [1:0] {
    SEL_8B   = 2'd0,
    SEL_16B  = 2'd1,
    SEL_32B  = 2'd2,
    SEL_RSVD = 2'd3
  } lfsr_sel_e;

  // Bytes covered by the active datapath width; the reserved code acts as 32-bit.
  function automatic logic [3:0] active_mask(input logic [1:0] sel);
    case (lfsr_sel_e'(sel))
      SEL_8B:  active_mask = 4'b0001;
      SEL_16B: active_mask = 4'b0011;
      default: active_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/tx_scrambler_lfsr_byte_step.sv
// One byte of scrambling: eight Galois LFSR steps, LSB-first keystream,
// optional XOR onto the data byte.
module lfsr_byte_step #(
  parameter int unsigned     W    = 16,
  parameter logic [W-1:0]    TAPS = '0
) (
  input  logic [W-1:0] state_in,
  input  logic [7:0]   data_in,
  input  logic         xor_en,
  output logic [W-1:0] state_out,
  output logic [7:0]   data_out
);

  logic [7:0] ks;

  always_comb begin
    state_out = state_in;
    ks        = '0;
    // Keystream bits shift in from the top so the first bit lands in bit 0.
    for (int unsigned b = 0; b < 8; b++) begin
      ks        = {state_out[W-1], ks[7:1]};
      state_out = {state_out[W-2:0], 1'b0} ^ (state_out[W-1] ? TAPS : '0);
    end
    data_out = xor_en ? (data_in ^ ks) : data_in;
  end

endmodule

// File: rtl/tx_scrambler.sv
// Per-lane TX scrambler: Gen1/2 16-bit or Gen3+ 23-bit LFSR applied byte by
// byte with per-byte advance/XOR control; one registered output stage.
module tx_scrambler
  import tx_scrambler_pkg::*;
#(
  parameter logic [22:0] GEN3SEED = LFSR23_SEED_LANE0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dataIn,
  input  logic [3:0]  dataKIn,
  input  logic [1:0]  syncHeaderIn,
  input  logic        validIn,
  input  logic [2:0]  GEN,
  input  logic        patternReset,
  input  logic [1:0]  LFSRSel,
  input  logic [3:0]  advance,
  input  logic [3:0]  scramblingEnable,
  output logic [31:0] dataOut,
  output logic [3:0]  dataKOut,
  output logic [1:0]  syncHeaderOut,
  output logic        validOut
);

  logic [15:0] lfsr16;
  logic [22:0] lfsr23;
  logic [2:0]  prev_gen;

  logic        gen3;
  logic        gen_cross;
  logic [3:0]  step_en;
  logic [3:0]  xen;
  logic [31:0] scr;

  logic [4:0][15:0] s16;
  logic [4:0][22:0] s23;
  logic [3:0][15:0] n16;
  logic [3:0][22:0] n23;
  logic [3:0][7:0]  d16;
  logic [3:0][7:0]  d23;

  always_comb begin
    gen3      = (GEN >= 3'd3);
    gen_cross = gen3 != (prev_gen >= 3'd3);
    step_en   = active_mask(LFSRSel) & advance;
    xen       = gen3 ? scramblingEnable : ~dataKIn;
  end

  assign s16[0] = lfsr16;
  assign s23[0] = lfsr23;

  // Both chains are always evaluated; gen3 picks which result is used.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    lfsr_byte_step #(.W(16), .TAPS(LFSR16_TAPS)) u_step16 (
      .state_in  (s16[i]),
      .data_in   (dataIn[8*i +: 8]),
      .xor_en    (xen[i]),
      .state_out (n16[i]),
      .data_out  (d16[i])
    );

    lfsr_byte_step #(.W(23), .TAPS(LFSR23_TAPS)) u_step23 (
      .state_in  (s23[i]),
      .data_in   (dataIn[8*i +: 8]),
      .xor_en    (xen[i]),
      .state_out (n23[i]),
      .data_out  (d23[i])
    );

    assign s16[i+1]      = step_en[i] ? n16[i] : s16[i];
    assign s23[i+1]      = step_en[i] ? n23[i] : s23[i];
    assign scr[8*i +: 8] = !step_en[i] ? dataIn[8*i +: 8] :
                           (gen3 ? d23[i] : d16[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr16        <= LFSR16_SEED;
      lfsr23        <= GEN3SEED;
      prev_gen      <= '0;
      dataOut       <= '0;
      dataKOut      <= '0;
      syncHeaderOut <= '0;
      validOut      <= 1'b0;
    end else begin
      prev_gen <= GEN;
      validOut <= validIn;
      if (gen_cross) begin
        lfsr16 <= LFSR16_SEED;
        lfsr23 <= GEN3SEED;
      end else if (validIn) begin
        if (gen3) lfsr23 <= patternReset ? GEN3SEED : s23[4];
        else      lfsr16 <= patternReset ? LFSR16_SEED : s16[4];
      end
      if (validIn) begin
        dataOut       <= scr;
        dataKOut      <= dataKIn;
        syncHeaderOut <= syncHeaderIn;
      end
    end
  end

endmodule

// File: tb/tb_tx_scrambler.sv
// Self-checking bench for tx_scrambler: directed scramble sequences plus
// randomized words checked against a polynomial-arithmetic reference model.
module tb_tx_scrambler;

  localparam int unsigned POLY16 = 32'h0001_0039;
  localparam int unsigned POLY23 = 32'h00A1_0125;
  localparam int unsigned SEED16 = 32'h0000_FFFF;
  localparam int unsigned SEED23 = 32'h001D_BFBC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dataIn = '0;
  logic [3:0]  dataKIn = '0;
  logic [1:0]  syncHeaderIn = '0;
  logic        validIn = 1'b0;
  logic [2:0]  GEN = '0;
  logic        patternReset = 1'b0;
  logic [1:0]  LFSRSel = '0;
  logic [3:0]  advance = '0;
  logic [3:0]  scramblingEnable = '0;
  logic [31:0] dataOut;
  logic [3:0]  dataKOut;
  logic [1:0]  syncHeaderOut;
  logic        validOut;

  int tests = 0;
  int fails = 0;

  int unsigned m16, m23;
  bit          mprev3;
  logic [31:0] exp_d;
  logic [3:0]  exp_k;
  logic [1:0]  exp_sh;
  logic        exp_v;

  tx_scrambler #(.GEN3SEED(23'h1DBFBC)) dut (
    .clk(clk), .reset_n(reset_n), .dataIn(dataIn), .dataKIn(dataKIn),
    .syncHeaderIn(syncHeaderIn), .validIn(validIn), .GEN(GEN),
    .patternReset(patternReset), .LFSRSel(LFSRSel), .advance(advance),
    .scramblingEnable(scramblingEnable), .dataOut(dataOut), .dataKOut(dataKOut),
    .syncHeaderOut(syncHeaderOut), .validOut(validOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"}, dataOut, exp_d);
    chk({tag, ".k"}, {28'd0, dataKOut}, {28'd0, exp_k});
    chk({tag, ".sh"}, {30'd0, syncHeaderOut}, {30'd0, exp_sh});
    chk({tag, ".valid"}, {31'd0, validOut}, {31'd0, exp_v});
  endtask

  task automatic model_reset();
    m16 = SEED16; m23 = SEED23; mprev3 = 1'b0;
    exp_d = '0; exp_k = '0; exp_sh = '0; exp_v = 1'b0;
  endtask

  // Reference: keystream bit is the top coefficient; a step multiplies the
  // state polynomial by x modulo the generator.
  task automatic model_edge(input logic [31:0] d, input logic [3:0] k, input logic [1:0] sh,
                            input logic v, input logic [2:0] gen, input logic pr,
                            input logic [1:0] sel, input logic [3:0] adv, input logic [3:0] se);
    bit g3;
    int unsigned st, wid, poly, nact, kb, w;
    bit xe;
    g3   = (gen >= 3);
    st   = g3 ? m23 : m16;
    wid  = g3 ? 23 : 16;
    poly = g3 ? POLY23 : POLY16;
    nact = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
    w    = d;
    if (v) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nact && adv[i]) begin
          xe = g3 ? se[i] : !k[i];
          kb = 0;
          for (int b = 0; b < 8; b++) begin
            kb = kb | (((st >> (wid - 1)) & 1) << b);
            st = st << 1;
            if (((st >> wid) & 1) != 0) st = st ^ poly;
          end
          if (xe) w = w ^ (kb << (8 * i));
        end
      end
      if (pr) st = g3 ? SEED23 : SEED16;
      if (g3) m23 = st; else m16 = st;
      exp_d = w; exp_k = k; exp_sh = sh;
    end
    exp_v = v;
    if (g3 != mprev3) begin m16 = SEED16; m23 = SEED23; end
    mprev3 = g3;
  endtask

  task automatic drive(input string tag, input logic [31:0] d, input logic [3:0] k,
                       input logic [1:0] sh, input logic v, input logic [2:0] gen,
                       input logic pr, input logic [1:0] sel, input logic [3:0] adv,
                       input logic [3:0] se);
    dataIn = d; dataKIn = k; syncHeaderIn = sh; validIn = v; GEN = gen;
    patternReset = pr; LFSRSel = sel; advance = adv; scramblingEnable = se;
    model_edge(d, k, sh, v, gen, pr, sel, adv, se);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [31:0] r0, r1;
    logic [31:0] gold;
    logic [7:0]  g1seq [0:4];
    g1seq[0] = 8'hFF; g1seq[1] = 8'h17; g1seq[2] = 8'hC0; g1seq[3] = 8'h14; g1seq[4] = 8'hB2;

    model_reset();
    #2;
    chk_all("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    drive("idle_g1", 32'h0, 4'h0, 2'b00, 1'b0, 3'd1, 1'b0, 2'd0, 4'h0, 4'h0);

    // Gen1, 8-bit: known PCIe scrambler opening bytes
    for (int n = 0; n < 5; n++) begin
      drive("g1_8b", 32'h0, 4'h0, 2'b00, 1'b1, 3'd1, 1'b0, 2'd0, 4'h1, 4'h0);
      chk("g1_seq", {24'd0, dataOut[7:0]}, {24'd0, g1seq[n]});
    end

    // COM with reseed, then a fresh sequence
    drive("com_rst", {24'h000000, 8'hBC}, 4'b0001, 2'b00, 1'b1, 3'd1, 1'b1, 2'd2, 4'hF, 4'h0);
    chk("com_raw", {24'd0, dataOut[7:0]}, 32'h0000_00BC);
    chk("com_k", {28'd0, dataKOut}, 32'h1);
    drive("post_com", 32'h0, 4'h0, 2'b00, 1'b1, 3'd1, 1'b0, 2'd2, 4'hF, 4'h0);
    chk("post_com_w", dataOut, 32'h14C0_17FF);

    // Byte 1 held back: passes raw, does not consume keystream
    drive("rs", 32'h0, 4'h0, 2'b00, 1'b1, 3'd1, 1'b1, 2'd2, 4'hF, 4'h0);
    drive("adv1101", 32'h0, 4'h0, 2'b00, 1'b1, 3'd1, 1'b0, 2'd2, 4'b1101, 4'h0);
    chk("adv1101_w", dataOut, 32'hC017_00FF);
    drive("adv_next", 32'h0, 4'h0, 2'b00, 1'b1, 3'd1, 1'b0, 2'd0, 4'h1, 4'h0);
    chk("adv_next_b", {24'd0, dataOut[7:0]}, 32'h14);

    // Gen3: crossing reseeds; byte0 XOR disabled but still steps
    drive("idle_g3", 32'h0, 4'h0, 2'b00, 1'b0, 3'd3, 1'b0, 2'd2, 4'h0, 4'h0);
    r0 = $urandom;
    drive("g3_se", r0, 4'h0, 2'b01, 1'b1, 3'd3, 1'b0, 2'd2, 4'hF, 4'b1110);
    chk("g3_b0_raw", {24'd0, dataOut[7:0]}, {24'd0, r0[7:0]});
    drive("g3_next", 32'h0, 4'h0, 2'b10, 1'b1, 3'd3, 1'b0, 2'd2, 4'hF, 4'hF);

    // Randomized Gen3+ traffic, including valid gaps and reseeds
    for (int n = 0; n < 40; n++) begin
      r0 = $urandom; r1 = $urandom;
      drive("g3_rnd", r0, r1[3:0], r1[5:4], (r1[8:6] != 3'd0), 3'd3 + {1'b0, r1[10:9] == 2'd3, 1'b0},
            (r1[15:12] == 4'd0), r1[17:16], r1[21:18], r1[25:22]);
    end

    // Three-cycle valid gap mid-stream: outputs hold, sequence continues
    drive("gap_pre", 32'h0, 4'h0, 2'b00, 1'b1, 3'd4, 1'b0, 2'd2, 4'hF, 4'hF);
    gold = dataOut;
    for (int n = 0; n < 3; n++) begin
      drive("gap", 32'hDEADBEEF, 4'h0, 2'b11, 1'b0, 3'd4, 1'b1, 2'd2, 4'hF, 4'hF);
      chk("gap_hold", dataOut, gold);
    end
    drive("gap_post", 32'h0, 4'h0, 2'b00, 1'b1, 3'd4, 1'b0, 2'd2, 4'hF, 4'hF);

    // Randomized Gen1/2 traffic
    drive("idle_g2", 32'h0, 4'h0, 2'b00, 1'b0, 3'd2, 1'b0, 2'd2, 4'h0, 4'h0);
    for (int n = 0; n < 40; n++) begin
      r0 = $urandom; r1 = $urandom;
      drive("g12_rnd", r0, r1[3:0], r1[5:4], (r1[8:6] != 3'd0), {2'b00, r1[9]} + 3'd1,
            (r1[15:12] == 4'd0), r1[17:16], r1[21:18], r1[25:22]);
    end

    // One-cycle reset mid-stream, then Gen2 -> Gen3 switch
    drive("pre_rst", 32'h12345678, 4'h0, 2'b00, 1'b1, 3'd2, 1'b0, 2'd2, 4'hF, 4'h0);
    reset_n = 1'b0;
    #2;
    model_reset();
    chk_all("midrst");
    @(posedge clk); #1;
    chk_all("midrst_hold");
    reset_n = 1'b1;
    drive("rel_idle", 32'h0, 4'h0, 2'b00, 1'b0, 3'd2, 1'b0, 2'd2, 4'h0, 4'h0);
    drive("sw_idle", 32'h0, 4'h0, 2'b00, 1'b0, 3'd3, 1'b0, 2'd2, 4'h0, 4'h0);
    chk("sw_valid", {31'd0, validOut}, 32'h0);
    drive("g3_seed", 32'h0, 4'h0, 2'b01, 1'b1, 3'd3, 1'b0, 2'd2, 4'hF, 4'hF);
    drive("back_idle", 32'h0, 4'h0, 2'b00, 1'b0, 3'd2, 1'b0, 2'd0, 4'h0, 4'h0);
    drive("g2_seed", 32'h0, 4'h0, 2'b00, 1'b1, 3'd2, 1'b0, 2'd0, 4'h1, 4'h0);
    chk("g2_seed_b", {24'd0, dataOut[7:0]}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_scrambler.md
# tx_scrambler

Per-lane transmit data scrambler sitting directly downstream of `Master_Tx`. It consumes the raw TX word together with `Master_Tx` controls: `patternReset`, `LFSRSel`, `advance`, `scramblingEnable`. It applies the Gen1/2 16-bit LFSR or the Gen3+ 23-bit LFSR byte by byte and emits a registered scrambled word toward the PIPE TX interface. It owns all LFSR state; `Master_Tx` only decides when that state resets, advances and is applied.

## Interface
Parameters:
- `GEN3SEED`, default 23'h1DBFBC: lane-specific Gen3 seed (lane 0 value).

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `dataIn` input 32: raw TX word; byte i = `dataIn[8i+7:8i]`.
- `dataKIn` input 4: per-byte K flag (Gen1/2 only).
- `syncHeaderIn` input 2: Gen3 sync header, passed through.
- `validIn` input 1: word present this cycle.
- `GEN` input 3: link generation; <3 selects 16-bit LFSR.
- `patternReset` input 1: reseed the selected LFSR.
- `LFSRSel` input 2: active width. 0 = byte0, 1 = bytes0–1, 2 = bytes0–3, 3 = treated as 2.
- `advance` input 4: per-byte LFSR advance enable.
- `scramblingEnable` input 4: per-byte XOR enable, Gen3+.
- `dataOut` output 32: scrambled word.
- `dataKOut` output 4: delayed `dataKIn`.
- `syncHeaderOut` output 2: delayed `syncHeaderIn`.
- `validOut` output 1: delayed `validIn`.

## Operation
LFSRs:
- `lfsr16` uses polynomial x^16+x^5+x^4+x^3+1 in Galois form, seed 16'hFFFF.
- `lfsr23` uses polynomial x^23+x^21+x^16+x^8+x^5+x^2+1 in Galois form, seed `GEN3SEED`.
- Only the LFSR selected by `GEN` ever changes. The other holds its value.

Per-byte processing, bytes 0→3, restricted to active bytes per `LFSRSel`. Inactive bytes: `dataOut` byte = `dataIn` byte, no advance.
- Each data bit, LSB first, XORs with the LFSR output bit (`lfsr16[15]` or `lfsr23[22]`). The LFSR then steps once. 8 steps per byte.
- A byte with `advance[i]=0` neither steps the LFSR nor is XORed; it passes raw. Later bytes see the un-stepped state.
- XOR enable:
  - GEN<3: `!dataKIn[i]`.
  - GEN≥3: `scramblingEnable[i]`.
  - An advancing byte with XOR disabled still steps the LFSR 8 times.
- Total steps per cycle = 8 × popcount(`advance` & active mask), range 0..32.

Control rules:
- `patternReset=1`: the current word is processed with the current state. The LFSR is then loaded with its seed instead of the advanced value. Reseed has priority over advance.
- `validIn=0`: no LFSR update, `patternReset` ignored, `validOut` goes 0 next cycle, `dataOut` holds.
- A `GEN` change between <3 and ≥3 reseeds both LFSRs at the next edge; the word in that cycle still scrambles normally.

## Timing
- Latency 1 cycle: word at edge N appears on outputs after edge N; `dataKOut`, `syncHeaderOut`, `validOut` stay aligned with it.
- There is no backpressure; one word per cycle is accepted.
- Reset values: `lfsr16`=16'hFFFF, `lfsr23`=`GEN3SEED`, `dataOut`=0, `dataKOut`=0, `syncHeaderOut`=0, `validOut`=0, stored previous `GEN`=0.
- Reset asserted mid-stream discards the in-flight word immediately; after release the first word uses the seeds.
- Combinational depth is up to 32 chained steps. Implement as four unrolled byte stages, each an 8-step XOR network.

## Structure
- Shared package holds:
  - polynomial tap masks, `LFSR16_SEED`, `LFSR23_SEED_LANE0`;
  - `LFSRSel` encodings (`SEL_8B`=0, `SEL_16B`=1, `SEL_32B`=2);
  - the `SKP`/`COM` constants already used by `Master_Tx`.
- One sub-module, `lfsr_byte_step`, is natural. It is combinational and parameterized by width and tap mask: input state, data byte, xor enable; output next state and scrambled byte. Instantiate four per LFSR in a chain, with a bypass mux per byte for `advance[i]=0`.

## Test plan
- Gen1, `LFSRSel`=0, after reset, D-bytes 0x00 × 5 with `advance`=1 → `dataOut` bytes FF, 17, C0, 14, B2.
- Gen1, 32-bit, word {D00,D00,D00,K(COM)} with `patternReset`=1 → next word of four 0x00 D-bytes gives FF, 17, C0, 14; COM byte passes raw, `dataKOut`=4'b0001.
- Gen1, 32-bit, `advance`=4'b1101 on 0x00 D-bytes → byte1 raw 0x00. Bytes 0, 2, 3 = FF, 17, C0; the next word continues with 14.
- Gen3, `scramblingEnable`=4'b1110, all advance → byte0 raw, LFSR still stepped 32 times. Checked against a C model with seed 1DBFBC.
- `validIn`=0 for 3 cycles mid-stream → outputs hold, `validOut`=0, scramble sequence resumes unbroken.
- `reset_n` low for 1 cycle mid-stream, then GEN switch 2→3 → both LFSRs at seeds; `validOut`=0 until the next `validIn`.
